// File: rtl/cpu_sequencer.sv
// cpu_sequencer: multi-cycle control unit. Owns the bit-addressed program
// counter, latches the decoded instruction fields and sequences register-file,
// ALU, divider and I/O handshakes for each instruction.
// Optional feature macro: CPU_SEQ_DIVZERO_TRAP_EN. When it is defined, a div
// whose divisor reads as zero halts with fault 3 instead of starting the divider.
// Opcode map (opsz >= 5): 0 imm, 1 out, 2 imp, 3 ilt, 4 ieq, 5 igt, 6 inc,
// 7 dec, 8 add, 9 sub, 10 mul, 11 div, 12 and, 13 or, 14 xor, 15 jmp,
// 16 jlt, 17 jeq, 18 jgt; every other code is illegal.
// Write strobes (rf_we/rf_wsel/div_start) are decoded from registered state so
// that a write can land in the same cycle as div_done or an input transfer.
module cpu_sequencer #(
  parameter int opsz   = 5,
  parameter int rgsz   = 3,
  parameter int imsz   = 8,
  parameter int pcsz   = 8,
  parameter int codesz = 256,
  parameter int wdsz   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [pcsz-1:0] pc,
  input  logic [opsz-1:0] opcode,
  input  logic [rgsz-1:0] regop1,
  input  logic [rgsz-1:0] regop2,
  input  logic [imsz-1:0] immop1,
  output logic [rgsz-1:0] rf_ra1,
  output logic [rgsz-1:0] rf_ra2,
  input  logic [wdsz-1:0] rf_rdata1,
  input  logic [wdsz-1:0] rf_rdata2,
  output logic            rf_we,
  output logic [rgsz-1:0] rf_wa,
  output logic [1:0]      rf_wsel,
  output logic [wdsz-1:0] rf_wimm,
  output logic [opsz-1:0] alu_op,
  output logic            div_start,
  input  logic            div_done,
  output logic            in_ready,
  input  logic            in_valid,
  input  logic [wdsz-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [wdsz-1:0] out_data,
  output logic [2:0]      flags,
  output logic            halted,
  output logic [1:0]      fault
);

  localparam logic [opsz-1:0] op_imm = opsz'(5'd0);
  localparam logic [opsz-1:0] op_out = opsz'(5'd1);
  localparam logic [opsz-1:0] op_imp = opsz'(5'd2);
  localparam logic [opsz-1:0] op_ilt = opsz'(5'd3);
  localparam logic [opsz-1:0] op_ieq = opsz'(5'd4);
  localparam logic [opsz-1:0] op_igt = opsz'(5'd5);
  localparam logic [opsz-1:0] op_inc = opsz'(5'd6);
  localparam logic [opsz-1:0] op_dec = opsz'(5'd7);
  localparam logic [opsz-1:0] op_add = opsz'(5'd8);
  localparam logic [opsz-1:0] op_sub = opsz'(5'd9);
  localparam logic [opsz-1:0] op_mul = opsz'(5'd10);
  localparam logic [opsz-1:0] op_div = opsz'(5'd11);
  localparam logic [opsz-1:0] op_and = opsz'(5'd12);
  localparam logic [opsz-1:0] op_or  = opsz'(5'd13);
  localparam logic [opsz-1:0] op_xor = opsz'(5'd14);
  localparam logic [opsz-1:0] op_jmp = opsz'(5'd15);
  localparam logic [opsz-1:0] op_jlt = opsz'(5'd16);
  localparam logic [opsz-1:0] op_jeq = opsz'(5'd17);
  localparam logic [opsz-1:0] op_jgt = opsz'(5'd18);

  localparam logic [pcsz:0] code_lim = (pcsz+1)'(codesz);

  typedef enum logic [2:0] {
    st_fetch    = 3'd0,
    st_exec     = 3'd1,
    st_wait_div = 3'd2,
    st_wait_io  = 3'd3,
    st_halt     = 3'd4
  } state_t;

  // Instruction length in bits; zero marks an illegal opcode.
  function automatic logic [pcsz:0] inst_len(input logic [opsz-1:0] op);
    case (op)
      op_imm:                                      inst_len = (pcsz+1)'(opsz + rgsz + imsz);
      op_out, op_imp, op_ilt, op_ieq, op_igt,
      op_inc, op_dec:                              inst_len = (pcsz+1)'(opsz + rgsz);
      op_add, op_sub, op_mul, op_div, op_and,
      op_or, op_xor:                               inst_len = (pcsz+1)'(opsz + 2*rgsz);
      op_jmp, op_jlt, op_jeq, op_jgt:              inst_len = (pcsz+1)'(opsz + imsz);
      default:                                     inst_len = {(pcsz+1){1'b0}};
    endcase
  endfunction

  state_t          state_r;
  logic [pcsz-1:0] pc_r;
  logic [pcsz-1:0] pc_seq_r;
  logic [opsz-1:0] ir_op_r;
  logic [rgsz-1:0] ir_rg1_r;
  logic [rgsz-1:0] ir_rg2_r;
  logic [imsz-1:0] ir_imm_r;
  logic [2:0]      flags_r;
  logic            halted_r;
  logic [1:0]      fault_r;
  logic            in_ready_r;
  logic            out_valid_r;
  logic [wdsz-1:0] out_data_r;

  logic [pcsz:0]        len_s;
  logic [pcsz:0]        pc_end_s;
  logic [pcsz-1:0]      jmp_target_s;
  logic [wdsz+imsz-1:0] cmp_a_s;
  logic [wdsz+imsz-1:0] cmp_b_s;
  logic                 div_zero_s;
  logic                 rf_we_s;
  logic [1:0]           rf_wsel_s;
  logic                 div_start_s;
  logic                 unused_in_data_s;

  assign len_s        = inst_len(opcode);
  assign pc_end_s     = {1'b0, pc_r} + len_s;
  assign jmp_target_s = pcsz'(ir_imm_r);
  assign cmp_a_s      = (wdsz+imsz)'(rf_rdata1);
  assign cmp_b_s      = (wdsz+imsz)'(ir_imm_r);
  assign div_zero_s   = (rf_rdata2 == {wdsz{1'b0}});
  // in_data travels straight to the register file through the rf_wsel mux.
  assign unused_in_data_s = ^in_data;

  assign pc        = pc_r;
  assign rf_ra1    = ir_rg1_r;
  assign rf_ra2    = ir_rg2_r;
  assign rf_wa     = ir_rg1_r;
  assign rf_wimm   = wdsz'(ir_imm_r);
  assign alu_op    = ir_op_r;
  assign rf_we     = rf_we_s;
  assign rf_wsel   = rf_wsel_s;
  assign div_start = div_start_s;
  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign flags     = flags_r;
  assign halted    = halted_r;
  assign fault     = fault_r;

  // Decode write and divider strobes from the current state; reset masks them.
  always_comb begin
    rf_we_s     = 1'b0;
    rf_wsel_s   = 2'd0;
    div_start_s = 1'b0;
    if (!rst_n) begin
      rf_we_s = 1'b0;
    end else begin
      case (state_r)
        st_exec: begin
          case (ir_op_r)
            op_imm: begin
              rf_we_s   = 1'b1;
              rf_wsel_s = 2'd1;
            end
            op_inc, op_dec, op_add, op_sub, op_mul, op_and, op_or, op_xor: begin
              rf_we_s   = 1'b1;
              rf_wsel_s = 2'd0;
            end
            op_div: begin
`ifdef CPU_SEQ_DIVZERO_TRAP_EN
              div_start_s = !div_zero_s;
`else
              div_start_s = 1'b1;
`endif
            end
            default: rf_we_s = 1'b0;
          endcase
        end
        st_wait_div: begin
          rf_wsel_s = 2'd3;
          rf_we_s   = div_done;
        end
        st_wait_io: begin
          rf_wsel_s = 2'd2;
          rf_we_s   = (ir_op_r == op_imp) && in_ready_r && in_valid;
        end
        default: rf_we_s = 1'b0;
      endcase
    end
  end

  // Main sequencer: state, PC, instruction register, flags and handshake strobes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= st_fetch;
      pc_r        <= {pcsz{1'b0}};
      pc_seq_r    <= {pcsz{1'b0}};
      ir_op_r     <= {opsz{1'b0}};
      ir_rg1_r    <= {rgsz{1'b0}};
      ir_rg2_r    <= {rgsz{1'b0}};
      ir_imm_r    <= {imsz{1'b0}};
      flags_r     <= 3'b000;
      halted_r    <= 1'b0;
      fault_r     <= 2'd0;
      in_ready_r  <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= {wdsz{1'b0}};
    end else begin
      case (state_r)
        st_fetch: begin
          ir_op_r  <= opcode;
          ir_rg1_r <= regop1;
          ir_rg2_r <= regop2;
          ir_imm_r <= immop1;
          pc_seq_r <= pc_end_s[pcsz-1:0];
          if (len_s == {(pcsz+1){1'b0}}) begin
            state_r  <= st_halt;
            halted_r <= 1'b1;
            fault_r  <= 2'd1;
          end else if (pc_end_s > code_lim) begin
            state_r  <= st_halt;
            halted_r <= 1'b1;
            fault_r  <= 2'd2;
          end else begin
            state_r <= st_exec;
          end
        end
        st_exec: begin
          case (ir_op_r)
            op_ilt, op_ieq, op_igt: begin
              flags_r <= {cmp_a_s < cmp_b_s, cmp_a_s == cmp_b_s, cmp_a_s > cmp_b_s};
              pc_r    <= pc_seq_r;
              state_r <= st_fetch;
            end
            op_jmp: begin
              pc_r    <= jmp_target_s;
              state_r <= st_fetch;
            end
            op_jlt: begin
              pc_r    <= flags_r[2] ? jmp_target_s : pc_seq_r;
              state_r <= st_fetch;
            end
            op_jeq: begin
              pc_r    <= flags_r[1] ? jmp_target_s : pc_seq_r;
              state_r <= st_fetch;
            end
            op_jgt: begin
              pc_r    <= flags_r[0] ? jmp_target_s : pc_seq_r;
              state_r <= st_fetch;
            end
            op_div: begin
`ifdef CPU_SEQ_DIVZERO_TRAP_EN
              if (div_zero_s) begin
                state_r  <= st_halt;
                halted_r <= 1'b1;
                fault_r  <= 2'd3;
              end else begin
                state_r <= st_wait_div;
              end
`else
              state_r <= st_wait_div;
`endif
            end
            op_imp: begin
              in_ready_r <= 1'b1;
              state_r    <= st_wait_io;
            end
            op_out: begin
              out_valid_r <= 1'b1;
              out_data_r  <= rf_rdata1;
              state_r     <= st_wait_io;
            end
            op_imm, op_inc, op_dec, op_add, op_sub, op_mul, op_and, op_or, op_xor: begin
              pc_r    <= pc_seq_r;
              state_r <= st_fetch;
            end
            default: begin
              state_r  <= st_halt;
              halted_r <= 1'b1;
              fault_r  <= 2'd1;
            end
          endcase
        end
        st_wait_div: begin
          if (div_done) begin
            pc_r    <= pc_seq_r;
            state_r <= st_fetch;
          end else begin
            state_r <= st_wait_div;
          end
        end
        st_wait_io: begin
          if ((in_ready_r && in_valid) || (out_valid_r && out_ready)) begin
            in_ready_r  <= 1'b0;
            out_valid_r <= 1'b0;
            pc_r        <= pc_seq_r;
            state_r     <= st_fetch;
          end else begin
            state_r <= st_wait_io;
          end
        end
        st_halt: begin
          halted_r <= 1'b1;
        end
        default: begin
          state_r     <= st_halt;
          halted_r    <= 1'b1;
          in_ready_r  <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a code-store/decoder model indexed by pc
// and a small register-file model feed the DUT; outputs are checked at negedge.
module tb_cpu_sequencer;

  localparam int opsz = 5, rgsz = 3, imsz = 8, pcsz = 8, codesz = 256, wdsz = 8;

  localparam logic [4:0] o_imm = 5'd0,  o_out = 5'd1,  o_imp = 5'd2,  o_ieq = 5'd4;
  localparam logic [4:0] o_inc = 5'd6,  o_add = 5'd8,  o_div = 5'd11, o_jmp = 5'd15;
  localparam logic [4:0] o_jeq = 5'd17, o_bad = 5'd31;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [pcsz-1:0] pc;
  logic [opsz-1:0] opcode;
  logic [rgsz-1:0] regop1, regop2, rf_ra1, rf_ra2, rf_wa;
  logic [imsz-1:0] immop1;
  logic [wdsz-1:0] rf_rdata1, rf_rdata2, rf_wimm, in_data, out_data;
  logic            rf_we, div_start, div_done, in_ready, in_valid, out_valid, out_ready, halted;
  logic [1:0]      rf_wsel, fault;
  logic [opsz-1:0] alu_op;
  logic [2:0]      flags;

  logic [4:0] prog_op [0:255];
  logic [2:0] prog_r1 [0:255];
  logic [2:0] prog_r2 [0:255];
  logic [7:0] prog_im [0:255];
  logic [7:0] rf [0:7];

  int errors = 0;
  int checks = 0;
  int div_cnt = 0;
  int we_cnt = 0;
  int div_base;
  int we_base;

  assign opcode    = prog_op[pc];
  assign regop1    = prog_r1[pc];
  assign regop2    = prog_r2[pc];
  assign immop1    = prog_im[pc];
  assign rf_rdata1 = rf[rf_ra1];
  assign rf_rdata2 = rf[rf_ra2];

  cpu_sequencer #(.opsz(opsz), .rgsz(rgsz), .imsz(imsz), .pcsz(pcsz), .codesz(codesz), .wdsz(wdsz)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .opcode(opcode), .regop1(regop1), .regop2(regop2),
    .immop1(immop1), .rf_ra1(rf_ra1), .rf_ra2(rf_ra2), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wsel(rf_wsel), .rf_wimm(rf_wimm), .alu_op(alu_op),
    .div_start(div_start), .div_done(div_done), .in_ready(in_ready), .in_valid(in_valid),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flags(flags), .halted(halted), .fault(fault)
  );

  // Free-running clock, 10 time-unit period.
  always #5 clk = ~clk;

  // Count divider launches and register writes seen at each active edge.
  always @(posedge clk) begin
    if (div_start) div_cnt <= div_cnt + 1;
    if (rf_we) we_cnt <= we_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic load(input int a, input logic [4:0] op, input logic [2:0] r1,
                      input logic [2:0] r2, input logic [7:0] im);
    prog_op[a] = op;
    prog_r1[a] = r1;
    prog_r2[a] = r2;
    prog_im[a] = im;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nxt();
    nxt();
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; div_done = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    for (int i = 0; i < 256; i++) load(i, o_bad, 3'd0, 3'd0, 8'h00);
    for (int i = 0; i < 8; i++) rf[i] = 8'h00;
    rf[1] = 8'h5A; rf[3] = 8'hC3; rf[6] = 8'h03;

    // Program: lengths imm=16, one-reg=8, two-reg=11, jump=13
    load(0,  o_imm, 3'd2, 3'd0, 8'h5A);
    load(16, o_ieq, 3'd1, 3'd0, 8'h5A);
    load(24, o_jeq, 3'd0, 3'd0, 8'h20);
    load(32, o_ieq, 3'd1, 3'd0, 8'h5A);
    load(40, o_jeq, 3'd0, 3'd0, 8'h60);
    load(53, o_out, 3'd3, 3'd0, 8'h00);
    load(61, o_imp, 3'd4, 3'd0, 8'h00);
    load(69, o_div, 3'd5, 3'd6, 8'h00);
    load(80, o_inc, 3'd0, 3'd0, 8'h00);
    load(88, o_jmp, 3'd0, 3'd0, 8'h08);

    nxt(); nxt();
    rst_n = 1'b1;
    #1;
    chk("rst_pc", 32'(pc), 32'h0);
    chk("rst_flags", 32'(flags), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_strobes", 32'({rf_we, div_start, in_ready, out_valid}), 32'h0);

    nxt();
    chk("imm_we", 32'({rf_we, rf_wsel}), 32'h5);
    chk("imm_wa", 32'(rf_wa), 32'h2);
    chk("imm_wimm", 32'(rf_wimm), 32'h5A);
    nxt();
    chk("imm_pc", 32'(pc), 32'd16);

    nxt(); nxt();
    chk("ieq_eq_flags", 32'(flags), 32'b010);
    chk("ieq_pc", 32'(pc), 32'd24);
    nxt(); nxt();
    chk("jeq_taken_pc", 32'(pc), 32'h20);
    rf[1] = 8'h10;
    nxt(); nxt();
    chk("ieq_lt_flags", 32'(flags), 32'b100);
    nxt(); nxt();
    chk("jeq_fall_pc", 32'(pc), 32'd53);

    nxt(); nxt();
    for (int i = 0; i < 4; i++) begin
      chk("out_valid_hold", 32'(out_valid), 32'h1);
      chk("out_data_hold", 32'(out_data), 32'hC3);
      chk("out_pc_hold", 32'(pc), 32'd53);
      rf[3] = 8'(i);
      nxt();
    end
    out_ready = 1'b1;
    nxt();
    chk("out_done_valid", 32'(out_valid), 32'h0);
    chk("out_done_pc", 32'(pc), 32'd61);
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_data = 8'h77;

    nxt();
    chk("imp_exec", 32'({in_ready, rf_we}), 32'h0);
    nxt();
    chk("imp_xfer", 32'({in_ready, rf_we, rf_wsel}), 32'hE);
    chk("imp_wa", 32'(rf_wa), 32'h4);
    nxt();
    chk("imp_done", 32'({in_ready, rf_we}), 32'h0);
    chk("imp_pc", 32'(pc), 32'd69);
    in_valid = 1'b0;

    div_base = div_cnt;
    nxt();
    chk("div_start", 32'(div_start), 32'h1);
    for (int i = 0; i < 4; i++) begin
      nxt();
      chk("div_wait", 32'({div_start, rf_we}), 32'h0);
    end
    nxt();
    div_done = 1'b1;
    #1;
    chk("div_wb", 32'({rf_we, rf_wsel}), 32'h7);
    chk("div_wa", 32'(rf_wa), 32'h5);
    nxt();
    div_done = 1'b0;
    chk("div_pc", 32'(pc), 32'd80);
    chk("div_pulses", 32'(div_cnt - div_base), 32'h1);

    nxt();
    chk("inc_we", 32'({rf_we, rf_wsel}), 32'h4);
    nxt(); nxt(); nxt();
    chk("jmp_pc", 32'(pc), 32'd8);
    nxt();
    chk("ill_state", 32'({halted, fault}), 32'h5);
    nxt(); nxt();
    chk("ill_sticky", 32'({halted, fault, rf_we}), 32'hA);
    chk("ill_pc", 32'(pc), 32'd8);

    // Reset while waiting for input must abort without a write
    load(0, o_imp, 3'd1, 3'd0, 8'h00);
    do_reset();
    nxt(); nxt();
    chk("rio_ready", 32'(in_ready), 32'h1);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("rio_no_we", 32'(rf_we), 32'h0);
    nxt();
    chk("rio_after", 32'({pc, in_ready, out_valid, halted, fault}), 32'h0);
    in_valid = 1'b0;

    // Two-register instruction straddling the end of code
    load(0, o_jmp, 3'd0, 3'd0, 8'd248);
    load(248, o_add, 3'd1, 3'd2, 8'h00);
    rst_n = 1'b1;
    we_base = we_cnt;
    nxt(); nxt();
    chk("ovr_pc", 32'(pc), 32'd248);
    nxt();
    chk("ovr_fault", 32'({halted, fault}), 32'h6);
    nxt();
    chk("ovr_no_we", 32'(we_cnt - we_base), 32'h0);
    chk("ovr_pc_frozen", 32'(pc), 32'd248);

    // Divide with a zero divisor
    load(0, o_div, 3'd5, 3'd6, 8'h00);
    rf[6] = 8'h00;
    do_reset();
    nxt();
`ifdef CPU_SEQ_DIVZERO_TRAP_EN
    chk("dz_no_start", 32'(div_start), 32'h0);
    nxt();
    chk("dz_fault", 32'({halted, fault}), 32'h7);
    chk("dz_pc", 32'(pc), 32'h0);
`else
    chk("dz_start", 32'(div_start), 32'h1);
    nxt();
    div_done = 1'b1;
    #1;
    chk("dz_wb", 32'({rf_we, rf_wsel}), 32'h7);
    nxt();
    div_done = 1'b0;
    chk("dz_pc", 32'(pc), 32'd11);
    chk("dz_no_fault", 32'({halted, fault}), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
